bram_port_arbiter: RTL and testbench

//  Shares one RAMB8BWER port between the video scanout reader (priority) and the
//  CA update engine (read/write). Clears the RAM after reset or on request,

---
 rtl/bram_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Single-port BRAM arbiter: clears the RAM after reset or on request, then shares the
// port between a priority video reader and the CA engine, returning tagged read data.
module bram_port_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              ready,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [1:0]        eng_be,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic              eng_gnt,
  output logic              eng_rvalid,
  output logic [DATA_W-1:0] eng_rdata,
  output logic              ram_en,
  output logic [1:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_regce,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int unsigned PIPE_N = RD_LAT + 2;
  localparam int unsigned SW     = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic                r_clr_last;
  logic                r_ready;
  logic                r_ram_en;
  logic [1:0]          r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_din;
  logic [SW-1:0]       r_starve;
  logic [PIPE_N-1:0]   r_pv;
  logic [PIPE_N-1:0]   r_pt;
  logic [DATA_W-1:0]   r_cap;
  logic                r_vid_rvalid;
  logic                r_eng_rvalid;
  logic [DATA_W-1:0]   r_vid_rdata;
  logic [DATA_W-1:0]   r_eng_rdata;

  logic w_run;
  logic w_eng_gnt;
  logic w_vid_gnt;
  logic w_rd_acc;

  always_comb begin
    w_run     = (r_state == S_RUN);
    w_eng_gnt = w_run && eng_req && (!vid_req || (r_starve == STARVE_LIM));
    w_vid_gnt = w_run && vid_req && !w_eng_gnt;
    w_rd_acc  = w_vid_gnt || (w_eng_gnt && !eng_we);
  end

  // The last clear write is issued one edge before RUN so that ready rises
  // only after the final word has actually been written by the BRAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_CLEAR;
      r_clr_cnt  <= '0;
      r_clr_last <= 1'b0;
      r_ready    <= 1'b0;
      r_ram_en   <= 1'b0;
      r_ram_we   <= '0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
    end else begin
      r_ram_en <= 1'b0;
      r_ram_we <= '0;
      case (r_state)
        S_CLEAR: begin
          if (r_clr_last) begin
            r_clr_last <= 1'b0;
            r_state    <= S_RUN;
            r_ready    <= 1'b1;
          end else begin
            r_ram_en   <= 1'b1;
            r_ram_we   <= '1;
            r_ram_addr <= r_clr_cnt;
            r_ram_din  <= CLR_VAL;
            r_clr_cnt  <= r_clr_cnt + 1'b1;
            if (r_clr_cnt == '1) r_clr_last <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_eng_gnt) begin
            r_ram_en   <= 1'b1;
            r_ram_we   <= eng_we ? eng_be : 2'b00;
            r_ram_addr <= eng_addr;
            r_ram_din  <= eng_wdata;
          end else if (w_vid_gnt) begin
            r_ram_en   <= 1'b1;
            r_ram_addr <= vid_addr;
          end
          if (clr) begin
            r_state <= S_DRAIN;
            r_ready <= 1'b0;
          end
        end
        S_DRAIN: begin
          // Only the output stage may still be busy; its data is already captured.
          if (r_pv[RD_LAT:0] == '0) r_state <= S_CLEAR;
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve     <= '0;
      r_pv         <= '0;
      r_pt         <= '0;
      r_cap        <= '0;
      r_vid_rvalid <= 1'b0;
      r_eng_rvalid <= 1'b0;
      r_vid_rdata  <= '0;
      r_eng_rdata  <= '0;
    end else begin
      if (!eng_req || w_eng_gnt) begin
        r_starve <= '0;
      end else if (w_vid_gnt && (r_starve != STARVE_LIM)) begin
        r_starve <= r_starve + 1'b1;
      end

      r_pv <= {r_pv[PIPE_N-2:0], w_rd_acc};
      r_pt <= {r_pt[PIPE_N-2:0], w_eng_gnt};

      if (r_pv[RD_LAT]) r_cap <= ram_dout;

      r_vid_rvalid <= r_pv[PIPE_N-1] && !r_pt[PIPE_N-1];
      r_eng_rvalid <= r_pv[PIPE_N-1] &&  r_pt[PIPE_N-1];
      if (r_pv[PIPE_N-1] && !r_pt[PIPE_N-1]) r_vid_rdata <= r_cap;
      if (r_pv[PIPE_N-1] &&  r_pt[PIPE_N-1]) r_eng_rdata <= r_cap;
    end
  end

  assign ready      = r_ready;
  assign vid_gnt    = w_vid_gnt;
  assign eng_gnt    = w_eng_gnt;
  assign vid_rvalid = r_vid_rvalid;
  assign vid_rdata  = r_vid_rdata;
  assign eng_rvalid = r_eng_rvalid;
  assign eng_rdata  = r_eng_rdata;
  assign ram_en     = r_ram_en;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_din    = r_ram_din;
  assign ram_regce  = 1'b1;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: RD_LAT=1 and RD_LAT=2 instances share stimulus and are
// each checked against a transaction-level reference (memory image + return schedule).
module tb_bram_port_arbiter;

  localparam int unsigned AW   = 4;
  localparam int unsigned DEP  = 16;
  localparam int SMAX          = 4;
  localparam logic [15:0] CV   = 16'h5A3C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] clr_v = '0;
  logic vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic eng_req = 1'b0;
  logic eng_we = 1'b0;
  logic [1:0] eng_be = '0;
  logic [AW-1:0] eng_addr = '0;
  logic [15:0] eng_wdata = '0;

  logic [1:0] rdy, vgn, egn, vrv, erv, ren, rce;
  logic [1:0][15:0] vrd, erd, rdin, rdo;
  logic [1:0][1:0] rwe;
  logic [1:0][AW-1:0] raddr;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [15:0] mem [DEP];
    logic [15:0] q1, q2;

    bram_port_arbiter #(
      .ADDR_W(AW), .DATA_W(16), .RD_LAT(g + 1), .STARVE_MAX(SMAX), .CLR_VAL(CV)
    ) u_dut (
      .clk(clk), .rst(rst), .clr(clr_v[g]), .ready(rdy[g]),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vgn[g]),
      .vid_rvalid(vrv[g]), .vid_rdata(vrd[g]),
      .eng_req(eng_req), .eng_we(eng_we), .eng_be(eng_be), .eng_addr(eng_addr),
      .eng_wdata(eng_wdata), .eng_gnt(egn[g]), .eng_rvalid(erv[g]), .eng_rdata(erd[g]),
      .ram_en(ren[g]), .ram_we(rwe[g]), .ram_addr(raddr[g]), .ram_din(rdin[g]),
      .ram_regce(rce[g]), .ram_dout(rdo[g])
    );

    // BRAM behaviour: NO_CHANGE on writes, optional output register
    always @(posedge clk) begin
      q2 <= q1;
      if (ren[g]) begin
        if (rwe[g] == 2'b00) q1 <= mem[raddr[g]];
        else begin
          if (rwe[g][0]) mem[raddr[g]][7:0]  <= rdin[g][7:0];
          if (rwe[g][1]) mem[raddr[g]][15:8] <= rdin[g][15:8];
        end
      end
    end
    assign rdo[g] = (g == 0) ? q1 : q2;
  end

  typedef struct {
    int          dut;
    int          due;
    bit          eng;
    logic [15:0] d;
  } ret_t;

  ret_t        pq[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          phase [2];   // 0 run, 1 clearing after reset, 2 draining/clearing after clr
  int          starve [2];
  int          clrcnt [2];
  bit          last_acc [2];
  logic [15:0] hv [2];
  logic [15:0] he [2];
  logic [15:0] refm [2][DEP];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic fill_ref(input int d);
    for (int a = 0; a < int'(DEP); a++) refm[d][a] = CV;
  endtask

  task automatic tick();
    logic eg, vg, vv, ev, run;
    int   lat, i;
    #1;
    for (int d = 0; d < 2; d++) begin
      lat = d + 1;
      if (phase[d] == 1 && cyc >= 17) phase[d] = 0;
      if (phase[d] == 2 && rdy[d]) begin
        chk($sformatf("d%0d_clear_words", d), clrcnt[d], 16);
        phase[d] = 0;
        starve[d] = 0;
      end
      run = (phase[d] == 0);
      if (phase[d] != 2) chk($sformatf("d%0d_ready", d), rdy[d], run);
      chk($sformatf("d%0d_regce", d), rce[d], 1);

      eg = run && eng_req && (!vid_req || starve[d] == SMAX);
      vg = run && vid_req && !eg;
      chk($sformatf("d%0d_eng_gnt", d), egn[d], eg);
      chk($sformatf("d%0d_vid_gnt", d), vgn[d], vg);

      if (phase[d] == 1) begin
        chk($sformatf("d%0d_clr_en", d), ren[d], (cyc >= 1 && cyc <= 16));
        if (cyc >= 1 && cyc <= 16) begin
          chk($sformatf("d%0d_clr_addr", d), raddr[d], cyc - 1);
          chk($sformatf("d%0d_clr_we", d), rwe[d], 2'b11);
          chk($sformatf("d%0d_clr_din", d), rdin[d], CV);
        end
      end else if (phase[d] == 2 && !last_acc[d]) begin
        if (ren[d]) begin
          chk($sformatf("d%0d_clr2_addr", d), raddr[d], clrcnt[d]);
          chk($sformatf("d%0d_clr2_we", d), rwe[d], 2'b11);
          chk($sformatf("d%0d_clr2_din", d), rdin[d], CV);
          clrcnt[d]++;
        end
      end else begin
        chk($sformatf("d%0d_ram_en", d), ren[d], last_acc[d]);
      end

      vv = 1'b0;
      ev = 1'b0;
      i = 0;
      while (i < pq.size()) begin
        if (pq[i].dut == d && pq[i].due == cyc) begin
          if (pq[i].eng) begin ev = 1'b1; he[d] = pq[i].d; end
          else           begin vv = 1'b1; hv[d] = pq[i].d; end
          pq.delete(i);
        end else i++;
      end
      chk($sformatf("d%0d_vid_rvalid", d), vrv[d], vv);
      chk($sformatf("d%0d_eng_rvalid", d), erv[d], ev);
      chk($sformatf("d%0d_vid_rdata", d), vrd[d], hv[d]);
      chk($sformatf("d%0d_eng_rdata", d), erd[d], he[d]);

      last_acc[d] = eg || vg;
      if (eg && eng_we) begin
        if (eng_be[0]) refm[d][eng_addr][7:0]  = eng_wdata[7:0];
        if (eng_be[1]) refm[d][eng_addr][15:8] = eng_wdata[15:8];
      end else if (eg) begin
        pq.push_back('{dut: d, due: cyc + 1 + lat + 2, eng: 1'b1, d: refm[d][eng_addr]});
      end
      if (vg) pq.push_back('{dut: d, due: cyc + 1 + lat + 2, eng: 1'b0, d: refm[d][vid_addr]});
      if (!eng_req || eg) starve[d] = 0;
      else if (vg && starve[d] < SMAX) starve[d]++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_ready", d), rdy[d], 0);
      chk($sformatf("d%0d_rst_gnts", d), {vgn[d], egn[d]}, 0);
      chk($sformatf("d%0d_rst_rvalid", d), {vrv[d], erv[d]}, 0);
      chk($sformatf("d%0d_rst_rdata", d), {vrd[d], erd[d]}, 0);
      chk($sformatf("d%0d_rst_ram", d), {ren[d], rwe[d], raddr[d], rdin[d]}, 0);
      phase[d] = 1;
      starve[d] = 0;
      last_acc[d] = 1'b0;
      hv[d] = '0;
      he[d] = '0;
      fill_ref(d);
    end
    pq.delete();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic set_idle();
    vid_req = 1'b0;
    eng_req = 1'b0;
    eng_we  = 1'b0;
  endtask

  task automatic eng_op(input bit we, input logic [1:0] be, input logic [AW-1:0] a,
                        input logic [15:0] wd);
    eng_req = 1'b1;
    eng_we = we;
    eng_be = be;
    eng_addr = a;
    eng_wdata = wd;
    tick();
    set_idle();
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    repeat (19) tick();

    // directed engine write / partial write / read-back
    eng_op(1'b1, 2'b11, 4'd5, 16'hBEEF);
    eng_op(1'b0, 2'b00, 4'd5, 16'h0000);
    repeat (5) tick();
    eng_op(1'b1, 2'b01, 4'd5, 16'h1234);
    eng_op(1'b0, 2'b00, 4'd5, 16'h0000);
    repeat (5) tick();

    // both requesters held: engine forced a slot every STARVE_MAX video wins
    vid_req = 1'b1;
    eng_req = 1'b1;
    eng_we = 1'b0;
    for (int t = 0; t < 16; t++) begin
      vid_addr = AW'($urandom_range(DEP - 1));
      eng_addr = AW'($urandom_range(DEP - 1));
      tick();
    end
    set_idle();

    // randomized traffic
    for (int t = 0; t < 300; t++) begin
      vid_req   = ($urandom_range(99) < 55);
      vid_addr  = AW'($urandom_range(DEP - 1));
      eng_req   = ($urandom_range(99) < 60);
      eng_we    = $urandom_range(1);
      eng_be    = 2'($urandom_range(3));
      eng_addr  = AW'($urandom_range(DEP - 1));
      eng_wdata = 16'($urandom);
      tick();
    end
    set_idle();
    repeat (6) tick();

    // clr on the RD_LAT=1 instance during streaming video reads
    vid_req = 1'b1;
    for (int t = 0; t < 5; t++) begin vid_addr = AW'(t); tick(); end
    clr_v[0] = 1'b1;
    vid_addr = 4'd9;
    tick();
    clr_v[0] = 1'b0;
    phase[0] = 2;
    clrcnt[0] = 0;
    fill_ref(0);
    for (int t = 0; t < 80 && phase[0] == 2; t++) begin
      vid_addr = AW'($urandom_range(DEP - 1));
      tick();
    end
    chk("clr_ready_timeout", phase[0] == 0, 1);
    set_idle();
    repeat (2) tick();
    eng_op(1'b0, 2'b00, 4'd5, 16'h0000);
    repeat (6) tick();

    // reset with two reads in flight
    vid_req = 1'b1;
    vid_addr = 4'd3;
    tick();
    vid_addr = 4'd7;
    tick();
    do_reset();
    vid_addr = 4'd2;
    repeat (20) tick();
    set_idle();
    repeat (8) tick();
    chk("returns_pending", pq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
